// File: rtl/io_responder_pkg.sv
// Shared definitions for the I/O window responder: FSM state encoding,
// register offsets inside the 4-word window and STATUS bit positions.
// No ports; imported by io_responder and io_responder_timer.
package io_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] IO_OUT    = 2'd0;
    localparam logic [1:0] IO_IN     = 2'd1;
    localparam logic [1:0] IO_TIMER  = 2'd2;
    localparam logic [1:0] IO_STATUS = 2'd3;

    localparam int STATUS_OVF = 0;
    localparam int STATUS_TEN = 1;

endpackage

// File: rtl/io_responder_timer.sv
// Free-running timer with enable and sticky overflow flag.
// Ports:
//   Clk, Reset      clock, synchronous active-high reset
//   clear           committed write to TIMER, forces count to 0
//   ten_we, ten_wd  committed write to STATUS, new TEN value
//   ovf_w1c         committed write to STATUS with bit0 set
//   count           current timer value
//   ten             timer enable
//   ovf             sticky overflow flag
module io_responder_timer #(
    parameter int DataWidth = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 clear,
    input  logic                 ten_we,
    input  logic                 ten_wd,
    input  logic                 ovf_w1c,
    output logic [DataWidth-1:0] count,
    output logic                 ten,
    output logic                 ovf
);
    import io_responder_pkg::*;

    logic wrap;

    // A clear in the same cycle suppresses both the increment and the overflow.
    assign wrap = ten && !clear && (count == '1);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count <= '0;
            ten   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (ten_we) begin
                ten <= ten_wd;
            end
            if (clear) begin
                count <= '0;
            end else if (ten) begin
                count <= count + DataWidth'(1);
            end
            // Setting has priority over write-1-to-clear.
            if (wrap) begin
                ovf <= 1'b1;
            end else if (ovf_w1c) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/io_responder.sv
// Memory-bus responder for a 4-word I/O window (OUT, IN, TIMER, STATUS)
// with a Ready handshake and a fixed number of wait states.
// Ports:
//   Clk, Reset      clock, synchronous active-high reset
//   Address, DIn    CPU bus address and write data
//   Write_EN        1 = write, 0 = read (qualified by Mem_En)
//   Mem_En          access request, held by the CPU until Ready
//   DOut            read data, non-zero only while Ready
//   Ready           one-cycle completion strobe
//   PortIn          external input port
//   PortOut         external output port register
//   TimerIrq        sticky timer overflow
//
// state   | meaning
// IDLE    | waiting for a hit; Ready=0, DOut=0
// WAIT    | counting wait states; abort if the request goes away
// DONE    | Ready=1, DOut valid, write committed at end of cycle
module io_responder #(
    parameter int                   DataWidth  = 8,
    parameter int                   AddrWidth  = 8,
    parameter logic [AddrWidth-1:0] IOBase     = 'hF0,
    parameter int                   WaitStates = 2
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [AddrWidth-1:0] Address,
    input  logic [DataWidth-1:0] DIn,
    input  logic                 Write_EN,
    input  logic                 Mem_En,
    output logic [DataWidth-1:0] DOut,
    output logic                 Ready,
    input  logic [DataWidth-1:0] PortIn,
    output logic [DataWidth-1:0] PortOut,
    output logic                 TimerIrq
);
    import io_responder_pkg::*;

    localparam logic [3:0] WAIT_LOAD = (WaitStates > 0) ? 4'(WaitStates - 1) : 4'd0;

    state_t                 state, next_state;
    logic [3:0]             wait_cnt;
    logic [1:0]             req_off;
    logic                   req_we;
    logic [DataWidth-1:0]   req_data;
    logic                   hit;
    logic                   commit;
    logic [DataWidth-1:0]   rd_data;
    logic [DataWidth-1:0]   timer_count;
    logic                   timer_ten;
    logic                   timer_ovf;

    assign hit    = Mem_En && (Address[AddrWidth-1:2] == IOBase[AddrWidth-1:2]);
    assign commit = (state == ST_DONE) && req_we;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            req_off  <= 2'd0;
            req_we   <= 1'b0;
            req_data <= '0;
            PortOut  <= '0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && hit) begin
                req_off  <= Address[1:0];
                req_we   <= Write_EN;
                req_data <= DIn;
                wait_cnt <= WAIT_LOAD;
            end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (commit && req_off == IO_OUT) begin
                PortOut <= req_data;
            end
        end
    end

    always_comb begin
        next_state = state;
        Ready      = 1'b0;
        DOut       = '0;
        unique case (state)
            ST_IDLE: begin
                if (hit) begin
                    next_state = (WaitStates == 0) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Request withdrawn or address moved away: drop it silently.
                if (!hit) begin
                    next_state = ST_IDLE;
                end else if (wait_cnt == 4'd0) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
                Ready      = 1'b1;
                DOut       = rd_data;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_data = '0;
        unique case (req_off)
            IO_OUT:    rd_data = PortOut;
            IO_IN:     rd_data = PortIn;
            IO_TIMER:  rd_data = timer_count;
            IO_STATUS: begin
                rd_data[STATUS_OVF] = timer_ovf;
                rd_data[STATUS_TEN] = timer_ten;
            end
            default:   rd_data = '0;
        endcase
    end

    io_responder_timer #(
        .DataWidth(DataWidth)
    ) u_timer (
        .Clk     (Clk),
        .Reset   (Reset),
        .clear   (commit && req_off == IO_TIMER),
        .ten_we  (commit && req_off == IO_STATUS),
        .ten_wd  (req_data[STATUS_TEN]),
        .ovf_w1c (commit && req_off == IO_STATUS && req_data[STATUS_OVF]),
        .count   (timer_count),
        .ten     (timer_ten),
        .ovf     (timer_ovf)
    );

    assign TimerIrq = timer_ovf;

endmodule

// File: tb/tb_io_responder.sv
// Bench for io_responder: two instances (index 0: 2 wait states, index 1:
// no wait states) share the bus; each has its own Mem_En. A cycle-level
// model of the register window and timer predicts every output.
module tb_io_responder;

    logic            clk = 1'b0;
    logic            rst;
    logic [7:0]      addr, din, port_in;
    logic            we;
    logic [1:0]      men;
    logic [1:0][7:0] dout;
    logic [1:0]      rdy;
    logic [1:0][7:0] pout;
    logic [1:0]      irq;

    always #5 clk = ~clk;

    io_responder #(.DataWidth(8), .AddrWidth(8), .IOBase(8'hF0), .WaitStates(2)) dut_a (
        .Clk(clk), .Reset(rst), .Address(addr), .DIn(din), .Write_EN(we), .Mem_En(men[0]),
        .DOut(dout[0]), .Ready(rdy[0]), .PortIn(port_in), .PortOut(pout[0]), .TimerIrq(irq[0]));

    io_responder #(.DataWidth(8), .AddrWidth(8), .IOBase(8'hF0), .WaitStates(0)) dut_b (
        .Clk(clk), .Reset(rst), .Address(addr), .DIn(din), .Write_EN(we), .Mem_En(men[1]),
        .DOut(dout[1]), .Ready(rdy[1]), .PortIn(port_in), .PortOut(pout[1]), .TimerIrq(irq[1]));

    // ---------------- model ----------------
    int         cyc = 0;
    int         ws[2] = '{2, 0};
    int         m_done[2] = '{-1, -1};   // cycle in which Ready is due
    logic [1:0] m_off[2];
    logic       m_we[2];
    logic [7:0] m_data[2];
    logic [7:0] m_pout[2], m_timer[2];
    logic       m_ovf[2], m_ten[2];
    logic       wr_now, wrap_now;
    bit         chk_en = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_pout[d] = 8'h00; m_timer[d] = 8'h00; m_ovf[d] = 1'b0; m_ten[d] = 1'b0;
            end else begin
                wr_now   = (cyc == m_done[d]) && m_we[d];
                wrap_now = 1'b0;
                if (wr_now && m_off[d] == 2'd2) m_timer[d] = 8'h00;
                else if (m_ten[d]) begin
                    wrap_now   = (m_timer[d] == 8'hFF);
                    m_timer[d] = m_timer[d] + 8'd1;
                end
                if (wr_now && m_off[d] == 2'd3) begin
                    if (m_data[d][0]) m_ovf[d] = 1'b0;
                    m_ten[d] = m_data[d][1];
                end
                if (wrap_now) m_ovf[d] = 1'b1;
                if (wr_now && m_off[d] == 2'd0) m_pout[d] = m_data[d];
            end
        end
        cyc++;
    end

    // ---------------- per-cycle compare ----------------
    logic       exp_rdy;
    logic [7:0] exp_rd;

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                exp_rdy = (cyc == m_done[d]);
                exp_rd  = 8'h00;
                if (exp_rdy) begin
                    case (m_off[d])
                        2'd0: exp_rd = m_pout[d];
                        2'd1: exp_rd = port_in;
                        2'd2: exp_rd = m_timer[d];
                        default: exp_rd = {6'b0, m_ten[d], m_ovf[d]};
                    endcase
                end
                chk($sformatf("ready[%0d]", d), 32'(rdy[d]), 32'(exp_rdy));
                chk($sformatf("dout[%0d]", d), 32'(dout[d]), 32'(exp_rd));
                chk($sformatf("port_out[%0d]", d), 32'(pout[d]), 32'(m_pout[d]));
                chk($sformatf("timer_irq[%0d]", d), 32'(irq[d]), 32'(m_ovf[d]));
            end
        end
    end

    // ---------------- bus driver ----------------
    // Returns latency (cycles from request to Ready, -1 if none) and read data.
    // hold=1 leaves Mem_En high so the caller can chain the next request.
    task automatic access(input int d, input logic [7:0] a, input logic w, input logic [7:0] data,
                          input bit hold, output int lat, output logic [7:0] rd);
        int c0;
        addr = a; we = w; din = data; men[d] = 1'b1;
        c0 = cyc;
        if (a >= 8'hF0 && a <= 8'hF3) begin
            m_off[d]  = 2'(a - 8'hF0);
            m_we[d]   = w;
            m_data[d] = data;
            m_done[d] = c0 + ws[d] + 1;
        end
        lat = -1;
        rd  = 8'h00;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (rdy[d]) begin
                lat = cyc - c0;
                rd  = dout[d];
                break;
            end
        end
        @(posedge clk); #1;
        if (!hold) men[d] = 1'b0;
    endtask

    int         lat, lat_b, c0a, c0b;
    logic [7:0] rd, rd_b;

    initial begin
        rst = 1'b1; men = 2'b00; addr = 8'h00; din = 8'h00; we = 1'b0; port_in = 8'h00;
        for (int d = 0; d < 2; d++) begin
            m_off[d] = 2'd0; m_we[d] = 1'b0; m_data[d] = 8'h00;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        // reset state after idling
        repeat (5) @(posedge clk);
        #1;
        chk("rst_ready", 32'(rdy[0]), 32'd0);
        chk("rst_dout", 32'(dout[0]), 32'd0);
        chk("rst_port_out", 32'(pout[0]), 32'd0);
        chk("rst_irq", 32'(irq[0]), 32'd0);

        // write / read OUT with two wait states
        access(0, 8'hF0, 1'b1, 8'h5A, 1'b0, lat, rd);
        chk("wr_latency", 32'(lat), 32'd3);
        chk("port_out_5a", 32'(pout[0]), 32'h5A);
        access(0, 8'hF0, 1'b0, 8'h00, 1'b0, lat, rd);
        chk("rd_latency", 32'(lat), 32'd3);
        chk("rd_out", 32'(rd), 32'h5A);

        // IN port and a miss
        port_in = 8'hC3;
        access(0, 8'hF1, 1'b0, 8'h00, 1'b0, lat, rd);
        chk("rd_in", 32'(rd), 32'hC3);
        access(0, 8'h10, 1'b0, 8'h00, 1'b0, lat, rd);
        chk("miss_no_ready", 32'(lat), 32'(-1));

        // timer wrap, W1C, clear, and W1C aligned with the wrap
        access(0, 8'hF3, 1'b1, 8'h02, 1'b0, lat, rd);
        repeat (260) @(posedge clk);
        #1;
        chk("wrap_irq", 32'(irq[0]), 32'd1);
        access(0, 8'hF3, 1'b0, 8'h00, 1'b0, lat, rd);
        chk("status_rd", 32'(rd), 32'h03);
        access(0, 8'hF3, 1'b1, 8'h01, 1'b0, lat, rd);
        chk("w1c_irq", 32'(irq[0]), 32'd0);
        access(0, 8'hF3, 1'b1, 8'h02, 1'b0, lat, rd);
        access(0, 8'hF2, 1'b1, 8'hAB, 1'b0, lat, rd);
        access(0, 8'hF2, 1'b0, 8'h00, 1'b0, lat, rd);
        chk("timer_after_clear", 32'(rd), 32'd3);
        for (int i = 0; i < 300 && m_timer[0] != 8'd252; i++) begin
            @(posedge clk); #1;
        end
        access(0, 8'hF3, 1'b1, 8'h03, 1'b0, lat, rd);
        chk("set_beats_w1c", 32'(irq[0]), 32'd1);

        // abort by dropping Mem_En in WAIT
        addr = 8'hF0; we = 1'b1; din = 8'h77; men[0] = 1'b1;
        @(posedge clk); #1;
        men[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_port_out", 32'(pout[0]), 32'h5A);

        // reset during WAIT
        addr = 8'hF0; we = 1'b1; din = 8'h77; men[0] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1; men[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_drop_port_out", 32'(pout[0]), 32'd0);
        chk("reset_drop_irq", 32'(irq[0]), 32'd0);

        // zero wait states, back-to-back
        access(1, 8'hF0, 1'b1, 8'hA5, 1'b0, lat, rd);
        chk("ws0_latency", 32'(lat), 32'd1);
        c0a = cyc;
        access(1, 8'hF0, 1'b0, 8'h00, 1'b1, lat, rd);
        c0b = cyc;
        access(1, 8'hF3, 1'b0, 8'h00, 1'b0, lat_b, rd_b);
        chk("b2b_lat1", 32'(lat), 32'd1);
        chk("b2b_lat2", 32'(lat_b), 32'd1);
        chk("b2b_gap", 32'((c0b + lat_b) - (c0a + lat)), 32'd2);
        chk("b2b_rd", 32'(rd), 32'hA5);
        chk("b2b_status", 32'(rd_b), 32'h00);

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
